// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: serialises per-channel rise/fall pulses onto one valid/ready
// event stream. Requesters are served round-robin. A pulse that arrives while its
// requester already has an event pending is dropped and counted in a saturating counter.
// Optional feature macro: EDGE_ARB_TIMESTAMP_EN (adds a timestamp to each event).
module edge_event_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned OVF_W = 8,
  parameter int unsigned TS_W  = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [N_CH-1:0]                             rise_in,
  input  logic [N_CH-1:0]                             fall_in,
  input  logic                                        enable,
  output logic                                        evt_valid,
  input  logic                                        evt_ready,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  evt_chan,
  output logic                                        evt_is_rise,
  output logic                                        busy,
  output logic [OVF_W-1:0]                            ovf_cnt,
  output logic                                        ovf_flag,
  input  logic                                        ovf_clr
`ifdef EDGE_ARB_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]                             evt_ts
`endif
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned R    = 2 * N_CH;
  localparam int unsigned R_W  = $clog2(R);

  // Elaboration-time parameter range check
  if (N_CH < 1 || N_CH > 16 || OVF_W < 1 || TS_W < 1) begin : g_param_check
    $error("edge_event_arbiter: parameter out of range");
  end

  logic [R-1:0]   pending;
  logic [R_W-1:0] rr_ptr;

  logic [R-1:0]   req_c;
  logic [R-1:0]   cap_c;
  logic [R-1:0]   clr_mask_c;
  logic [R-1:0]   drop_c;
  logic [R-1:0]   pending_nxt_c;
  logic           ovf_any_c;
  logic           load_en_c;
  logic           do_load_c;
  logic           grant_found_c;
  logic [R_W-1:0] grant_idx_c;
  logic [R_W-1:0] cand_c;
  logic [R_W-1:0] rr_nxt_c;
  logic           evt_valid_nxt_c;

  // Interleave pulses into requester order: r = 2*c + (fall ? 1 : 0)
  always_comb begin
    req_c = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      req_c[2*c]     = rise_in[c];
      req_c[2*c + 1] = fall_in[c];
    end
  end

  // Round-robin pick: first pending requester at or after rr_ptr, wrapping
  always_comb begin
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    cand_c        = '0;
    for (int unsigned i = 0; i < R; i++) begin
      cand_c = R_W'((32'(rr_ptr) + i) % R);
      if (!grant_found_c && pending[cand_c]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = cand_c;
      end
    end
  end

  // Capture, load and overflow decisions for this cycle
  always_comb begin
    load_en_c       = !evt_valid || evt_ready;
    do_load_c       = load_en_c && grant_found_c;
    clr_mask_c      = do_load_c ? (R'(1) << grant_idx_c) : '0;
    cap_c           = enable ? req_c : '0;
    drop_c          = cap_c & pending & ~clr_mask_c;
    ovf_any_c       = |drop_c;
    pending_nxt_c   = (pending & ~clr_mask_c) | cap_c;
    rr_nxt_c        = (grant_idx_c == R_W'(R - 1)) ? '0 : grant_idx_c + R_W'(1);
    evt_valid_nxt_c = load_en_c ? grant_found_c : evt_valid;
  end

  // Pending set, round-robin pointer and output event stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      rr_ptr      <= '0;
      evt_valid   <= 1'b0;
      evt_chan    <= '0;
      evt_is_rise <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pending   <= pending_nxt_c;
      evt_valid <= evt_valid_nxt_c;
      busy      <= (|pending_nxt_c) || evt_valid_nxt_c;
      if (do_load_c) begin
        evt_chan    <= CH_W'(grant_idx_c >> 1);
        evt_is_rise <= ~grant_idx_c[0];
        rr_ptr      <= rr_nxt_c;
      end
    end
  end

  // Saturating drop counter and sticky flag; a same-cycle drop beats the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else if (ovf_any_c) begin
      ovf_flag <= 1'b1;
      if (ovf_clr) begin
        ovf_cnt <= OVF_W'(1);
      end else if (!(&ovf_cnt)) begin
        ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
    end else if (ovf_clr) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end
  end

`ifdef EDGE_ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_q [R];
  logic [R-1:0]    cap_new_c;

  // Pulses that actually set a pending bit (dropped ones keep the older stamp)
  always_comb begin
    cap_new_c = cap_c & ~drop_c;
  end

  // Free-running timestamp counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  // Per-requester stamp taken at capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < R; r++) begin
        ts_q[r] <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < R; r++) begin
        if (cap_new_c[r]) begin
          ts_q[r] <= ts_cnt;
        end
      end
    end
  end

  // Timestamp travels with the event payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_ts <= '0;
    end else if (do_load_c) begin
      evt_ts <= ts_q[grant_idx_c];
    end
  end
`else
  // Timestamp feature not built: no counter, stamps or evt_ts port.
`endif

endmodule
